// File: rtl/rip_bram_arbiter.sv
// ---------------------------------------------------------------------------
// rip_bram_arbiter
//
// Shares port 1 of a read-first, 1-cycle-latency block RAM between two
// requesters (m0, m1). Port 2 of the RAM is a dedicated, non-blocking fetch
// read path. Responses leave the RAM one cycle after acceptance; a requester
// that is not ready for its response gets it parked in a local hold register
// until it is.
//
// Ports
//   clk, rst                  single clock, synchronous active-high reset
//   mN_valid/ready            request handshake (N = 0, 1)
//   mN_addr/we/wdata          word address, byte strobes (0 = read), data
//   mN_rvalid/rready/rdata    response handshake and data
//   m1_lock                   keeps the RAM port with m1 across a burst
//   f_en/f_addr               fetch read request (RAM port 2)
//   f_rvalid/f_rdata          fetch data, one cycle after f_en
//   bram_*_1                  RAM port 1 (read/write, arbitrated)
//   bram_*_2                  RAM port 2 (read only, fetch)
// ---------------------------------------------------------------------------
package rip_const;
    localparam int B_WIDTH = 8;
endpackage

module rip_bram_arbiter
    import rip_const::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                           clk,
    input  logic                           rst,

    input  logic                           m0_valid,
    output logic                           m0_ready,
    input  logic [ADDR_WIDTH-1:0]          m0_addr,
    input  logic [DATA_WIDTH/B_WIDTH-1:0]  m0_we,
    input  logic [DATA_WIDTH-1:0]          m0_wdata,
    output logic                           m0_rvalid,
    input  logic                           m0_rready,
    output logic [DATA_WIDTH-1:0]          m0_rdata,

    input  logic                           m1_valid,
    output logic                           m1_ready,
    input  logic [ADDR_WIDTH-1:0]          m1_addr,
    input  logic [DATA_WIDTH/B_WIDTH-1:0]  m1_we,
    input  logic [DATA_WIDTH-1:0]          m1_wdata,
    output logic                           m1_rvalid,
    input  logic                           m1_rready,
    output logic [DATA_WIDTH-1:0]          m1_rdata,
    input  logic                           m1_lock,

    input  logic                           f_en,
    input  logic [ADDR_WIDTH-1:0]          f_addr,
    output logic                           f_rvalid,
    output logic [DATA_WIDTH-1:0]          f_rdata,

    output logic                           bram_enable_1,
    output logic [DATA_WIDTH/B_WIDTH-1:0]  bram_we_1,
    output logic [ADDR_WIDTH-1:0]          bram_addr_1,
    output logic [DATA_WIDTH-1:0]          bram_din_1,
    input  logic [DATA_WIDTH-1:0]          bram_dout_1,
    output logic                           bram_enable_2,
    output logic [ADDR_WIDTH-1:0]          bram_addr_2,
    input  logic [DATA_WIDTH-1:0]          bram_dout_2
);

    localparam int NB = DATA_WIDTH / B_WIDTH;

    // Per-requester state, bit N belongs to requester N.
    logic [1:0]                 pend_q, pend_d;   // response due this cycle
    logic [1:0]                 hold_q, hold_d;   // response parked
    logic [1:0][DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic                       last_gnt_q, last_gnt_d;
    logic                       lock_act_q, lock_act_d;
    logic                       f_pend_q;

    logic [1:0] rready;
    logic [1:0] elig;
    logic [1:0] gnt;

    assign rready = {m1_rready, m0_rready};

    // A requester may issue only when no parked response blocks it and any
    // response due now is being consumed this same cycle.
    assign elig[0] = m0_valid && !hold_q[0] && (!pend_q[0] || m0_rready);
    assign elig[1] = m1_valid && !hold_q[1] && (!pend_q[1] || m1_rready);

    // NOTE: every signal assigned in an always_comb gets a default at the
    // top of the block, so no path can leave it unassigned and infer a latch.
    always_comb begin
        gnt = '0;
        if (!rst) begin
            if (lock_act_q) begin
                gnt[1] = elig[1];
            end else if (elig[0] && elig[1]) begin
                // Round robin: favour whoever was not granted last.
                gnt[0] = last_gnt_q;
                gnt[1] = !last_gnt_q;
            end else begin
                gnt = elig;
            end
        end
    end

    // RAM port 1 request mux.
    always_comb begin
        bram_enable_1 = |gnt;
        bram_we_1     = '0;
        bram_addr_1   = m0_addr;
        bram_din_1    = m0_wdata;
        if (gnt[1]) begin
            bram_we_1   = m1_we;
            bram_addr_1 = m1_addr;
            bram_din_1  = m1_wdata;
        end else if (gnt[0]) begin
            bram_we_1   = m0_we;
        end
    end

    always_comb begin
        pend_d      = gnt;
        hold_d      = hold_q;
        hold_data_d = hold_data_q;
        for (int i = 0; i < 2; i++) begin
            if (hold_q[i] && rready[i]) begin
                hold_d[i] = 1'b0;
            end else if (pend_q[i] && !rready[i]) begin
                // RAM output is only valid for this one cycle; capture it.
                hold_d[i]      = 1'b1;
                hold_data_d[i] = bram_dout_1;
            end
        end

        last_gnt_d = last_gnt_q;
        if (gnt[1]) begin
            last_gnt_d = 1'b1;
        end else if (gnt[0]) begin
            last_gnt_d = 1'b0;
        end

        // Lock drops at the first edge that sees m1_lock low, whether or not
        // m1 is requesting.
        lock_act_d = lock_act_q;
        if (!m1_lock) begin
            lock_act_d = 1'b0;
        end else if (gnt[1]) begin
            lock_act_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q      <= '0;
            hold_q      <= '0;
            // NOTE: the parked data registers are reset as well, so a fresh
            // start never carries words from before the reset.
            hold_data_q <= '0;
            last_gnt_q  <= 1'b1;
            lock_act_q  <= 1'b0;
            f_pend_q    <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            hold_q      <= hold_d;
            hold_data_q <= hold_data_d;
            last_gnt_q  <= last_gnt_d;
            lock_act_q  <= lock_act_d;
            f_pend_q    <= f_en;
        end
    end

    assign m0_ready  = gnt[0];
    assign m1_ready  = gnt[1];
    assign m0_rvalid = !rst && (pend_q[0] || hold_q[0]);
    assign m1_rvalid = !rst && (pend_q[1] || hold_q[1]);
    assign m0_rdata  = hold_q[0] ? hold_data_q[0] : bram_dout_1;
    assign m1_rdata  = hold_q[1] ? hold_data_q[1] : bram_dout_1;

    // Fetch path: straight to RAM port 2, no arbitration or backpressure.
    // A same-cycle port 1 write to the same word returns the old word here
    // because the RAM is read-first.
    assign bram_enable_2 = f_en && !rst;
    assign bram_addr_2   = f_addr;
    assign f_rvalid      = f_pend_q && !rst;
    assign f_rdata       = bram_dout_2;

endmodule

// File: doc/rip_bram_arbiter.md
RIP_BRAM_ARBITER -- requirements
Module: rip_bram_arbiter

Interface
REQ-001 Parameters SHALL be as follows. NB denotes DATA_WIDTH/B_WIDTH, where B_WIDTH comes from the rip_const package.
- DATA_WIDTH, default 32, word width.
- ADDR_WIDTH, default 10, word-address width.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clk, in, 1: the single clock.
- rst, in, 1: reset, synchronous and active-high.
REQ-003 For each requester N in {0,1}, ports SHALL be:
- mN_valid, in, 1: request valid.
- mN_ready, out, 1: request accepted this cycle.
- mN_addr, in, ADDR_WIDTH: word address.
- mN_we, in, NB: byte write strobes; all-zero means read.
- mN_wdata, in, DATA_WIDTH: write data.
- mN_rvalid, out, 1: response valid.
- mN_rready, in, 1: response accepted.
- mN_rdata, out, DATA_WIDTH: response data.
REQ-004 Lock and fetch ports SHALL be:
- m1_lock, in, 1: requester 1 burst lock.
- f_en, in, 1: fetch read enable.
- f_addr, in, ADDR_WIDTH: fetch address.
- f_rvalid, out, 1: fetch data valid.
- f_rdata, out, DATA_WIDTH: fetch data.
REQ-005 Memory-side ports SHALL be:
- bram_enable_1, out, 1.
- bram_we_1, out, NB.
- bram_addr_1, out, ADDR_WIDTH.
- bram_din_1, out, DATA_WIDTH.
- bram_dout_1, in, DATA_WIDTH.
- bram_enable_2, out, 1.
- bram_addr_2, out, ADDR_WIDTH.
- bram_dout_2, in, DATA_WIDTH.
- Attached memory: read-first, 1-cycle read latency, dout holds while its enable is low.

Function
REQ-006 Internal state per requester SHALL be pend_N (response due next cycle) and hold_N plus hold_data_N (response parked). Shared state SHALL be last_gnt (1 bit), lock_act, and f_pend.
REQ-007 elig_N SHALL equal mN_valid && !hold_N && (!pend_N || mN_rready).
REQ-008 Grant SHALL be combinational, with at most one grant per cycle:
- lock_act=1: only m1 may be granted.
- Only one requester eligible: grant it.
- Both eligible: grant the one that is not last_gnt.
REQ-009 mN_ready SHALL equal gnt_N, and a request SHALL be accepted in the cycle where mN_valid && mN_ready.
REQ-010 On acceptance the block SHALL drive bram_enable_1=1 and the granted requester's addr, we and wdata.
- With no grant: bram_enable_1=0 and bram_we_1=0.
- On acceptance: pend_N<=1 and last_gnt<=N.
REQ-011 One cycle after acceptance (pend_N=1):
- mN_rvalid SHALL be 1 and mN_rdata SHALL equal bram_dout_1.
- pend_N clears unless re-granted.
- If mN_rready=0: hold_N<=1 and hold_data_N<=bram_dout_1.
REQ-012 While hold_N=1, mN_rvalid SHALL be 1 and mN_rdata SHALL equal hold_data_N; hold_N SHALL clear on the cycle mN_rready=1.
REQ-013 Writes SHALL produce a response like reads, with rdata equal to the pre-write word; partial strobes SHALL write only the selected bytes.
REQ-014 Back-to-back accepts to the same requester SHALL be allowed when its rready=1, giving 1 request/cycle throughput with responses in order.
REQ-015 lock_act SHALL behave as follows:
- Set when m1 is accepted with m1_lock=1.
- Cleared at the first clock edge sampling m1_lock=0.
- While lock_act=1, m0_ready=0 even if m1_valid=0.
REQ-016 The fetch port SHALL behave as follows:
- bram_enable_2=f_en and bram_addr_2=f_addr (combinational).
- f_pend<=f_en; f_rvalid=f_pend; f_rdata=bram_dout_2.
- No backpressure.
REQ-017 Fetch and a port-1 write to the same address in the same cycle SHALL return the old word on f_rdata.
REQ-018 When rst is high, no grant SHALL be issued and all ready outputs SHALL be 0.

Reset
REQ-019 Synchronous rst SHALL clear the following, and the reset state SHALL be:
- pend_N, hold_N, lock_act, f_pend <= 0; hold_data_N <= 0; last_gnt <= 1.
- Outputs: mN_rvalid, f_rvalid, mN_ready, bram_enable_* and bram_we_1 = 0.
REQ-020 Reset asserted mid-transaction SHALL drop in-flight and parked responses, with no rvalid in the cycle after rst deasserts.

Verification
REQ-021 Single read: m0 reads addr 0x10 holding 0xDEADBEEF, rready=1 -> m0_ready=1 at t, m0_rvalid=1 and rdata=0xDEADBEEF at t+1.
REQ-022 Contention: both valid for 4 cycles, rready=1 -> grants m0,m1,m0,m1, each response one cycle after its grant.
REQ-023 Partial write: m1 writes 0x000000AA with we=0001 to a word holding 0x11223344 -> response 0x11223344; a later read returns 0x112233AA.
REQ-024 Backpressure: m0 read with m0_rready=0 for 3 cycles -> rvalid held and rdata stable, m0_ready=0 meanwhile, m1 still served; hold clears at rready=1.
REQ-025 Lock: m1 accepted with m1_lock=1, then m1_valid=0 with m1_lock=1 for 2 cycles while m0_valid=1 -> m0_ready=0 until m1_lock=0 is sampled.
REQ-026 Fetch collision plus reset: f_en and an m0 write (0x5 to addr 3, old value 0x9) in the same cycle -> f_rdata=0x9; rst asserted while hold_0=1 -> m0_rvalid=0 after reset.
